// File: rtl/fu_br_pipe.sv
// fu_br_pipe: registered branch unit that resolves branches/jumps, checks the
// front-end prediction and presents the result through a valid/ready register.
package fu_br_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] i_imm;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
  } decode_info_t;
endpackage

module fu_br_pipe
  import fu_br_pkg::*;
#(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5,
  parameter int CNT_BITS      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     ready,
  input  logic [31:0]              rs1_v,
  input  logic [31:0]              rs2_v,
  input  decode_info_t             decode_info,
  input  logic [ROB_IDX_BITS-1:0]  rob_idx,
  input  logic [PHYS_REG_BITS-1:0] pd,
  input  logic                     pred_taken,
  input  logic [31:0]              pred_target,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     valid,
  output logic [31:0]              rd_v,
  output logic [ROB_IDX_BITS-1:0]  out_rob_idx,
  output logic [PHYS_REG_BITS-1:0] out_pd,
  output logic                     br_taken,
  output logic                     mispredict,
  output logic                     pc_select,
  output logic [31:0]              pc_branch,
  output logic [CNT_BITS-1:0]      br_count,
  output logic [CNT_BITS-1:0]      mp_count
);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  logic        is_jal, is_jalr, is_br, is_jump, cond, taken, mp, accept, out_is_br;
  logic [31:0] pc4, target;
  logic [2:0]  f3;
  assign is_jal  = decode_info.opcode == OP_JAL;
  assign is_jalr = decode_info.opcode == OP_JALR;
  assign is_br   = decode_info.opcode == OP_BR;
  assign is_jump = is_jal || is_jalr;
  assign f3      = decode_info.funct3;
  assign pc4     = decode_info.pc + 32'd4;
  always_comb begin
    cond = f3 == 3'b000 ? rs1_v == rs2_v :
           f3 == 3'b001 ? rs1_v != rs2_v :
           f3 == 3'b100 ? $signed(rs1_v) <  $signed(rs2_v) :
           f3 == 3'b101 ? $signed(rs1_v) >= $signed(rs2_v) :
           f3 == 3'b110 ? rs1_v <  rs2_v :
           f3 == 3'b111 ? rs1_v >= rs2_v : 1'b0;
    target = is_jal  ? decode_info.pc + decode_info.j_imm :
             is_jalr ? (rs1_v + decode_info.i_imm) & 32'hFFFF_FFFE :
                       decode_info.pc + decode_info.b_imm;
  end
  assign taken     = is_jump || (is_br && cond);
  assign mp        = (taken != pred_taken) || (taken && target != pred_target);
  assign ready     = (!valid || out_ready) && !flush;
  assign accept    = start && ready;
  assign pc_select = valid && mispredict;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= 1'b0;
      rd_v        <= '0;
      out_rob_idx <= '0;
      out_pd      <= '0;
      br_taken    <= 1'b0;
      mispredict  <= 1'b0;
      pc_branch   <= '0;
      out_is_br   <= 1'b0;
      br_count    <= '0;
      mp_count    <= '0;
    end else begin
      valid <= !flush && (accept || (valid && !out_ready));
      if (accept) begin
        rd_v        <= is_jump ? pc4 : 32'd0;
        out_rob_idx <= rob_idx;
        out_pd      <= pd;
        br_taken    <= taken;
        mispredict  <= mp;
        pc_branch   <= taken ? target : pc4;
        out_is_br   <= is_jump || is_br;
      end
      // a handshake-out still counts when a flush lands in the same cycle
      if (valid && out_ready) begin
        br_count <= br_count + CNT_BITS'(out_is_br);
        mp_count <= mp_count + CNT_BITS'(mispredict);
      end
    end
  end
endmodule

// File: doc/fu_br_pipe.md
# fu_br_pipe

Registered, prediction-checking branch functional unit. It is the pipelined successor to the combinational branch unit. It accepts one issued branch/jump per cycle with its ROB index, physical destination and front-end prediction. One cycle later it presents the resolved result in an output register with a valid/ready handshake. A redirect is raised only on misprediction. The block sits between the branch reservation station and the CDB/ROB writeback arbiter, and feeds the fetch redirect path.

## Interface
Parameters:
- PHYS_REG_BITS, 6, physical register index width
- ROB_IDX_BITS, 5, ROB index width
- CNT_BITS, 32, width of resolved-branch and mispredict counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  issue valid; accepted when start && ready
- ready  out  1  unit can accept this cycle
- rs1_v, rs2_v  in  32  source operands
- decode_info  in  decode_info_t  opcode, funct3, pc, i_imm, j_imm, b_imm
- rob_idx  in  ROB_IDX_BITS  ROB entry of issued op
- pd  in  PHYS_REG_BITS  physical destination
- pred_taken  in  1  front-end predicted direction
- pred_target  in  32  front-end predicted target
- flush  in  1  pipeline squash
- out_ready  in  1  writeback arbiter accepts result
- valid  out  1  result register holds a result
- rd_v  out  32  link value (pc+4 for jal/jalr, else 0)
- out_rob_idx  out  ROB_IDX_BITS  registered rob_idx
- out_pd  out  PHYS_REG_BITS  registered pd
- br_taken  out  1  resolved direction
- mispredict  out  1  resolved outcome differs from prediction
- pc_select  out  1  redirect fetch; equals valid && mispredict
- pc_branch  out  32  correct next PC
- br_count, mp_count  out  CNT_BITS  resolved / mispredicted op counters

## Operation
- Condition: funct3 selects beq, bne, blt, bge (signed), bltu, bgeu (unsigned). An undefined funct3 resolves not-taken.
- Target:
  - jal: pc + j_imm.
  - jalr: (rs1_v + i_imm) & 32'hFFFF_FFFE.
  - br: pc + b_imm.
  - All arithmetic is modulo 2^32.
- Taken: 1 for jal/jalr; the condition result for br; 0 for any other opcode.
- Next PC: taken ? target : pc + 4.
- mispredict = (taken != pred_taken) || (taken && target != pred_target).
- Non-branch opcode: accepted and produces a valid result with rd_v=0, br_taken=0, mispredict = pred_taken.
- Output register control state: EMPTY (valid=0) and FULL (valid=1).
  - EMPTY + accept → FULL.
  - FULL + out_ready + no accept → EMPTY.
  - FULL + out_ready + accept → FULL with new data.
  - FULL + !out_ready → hold all outputs stable.
- ready = (!valid || out_ready) && !flush.
- Flush: the next state is EMPTY regardless of start/out_ready, and the op presented that cycle is dropped. Counters are not incremented for dropped ops.
- Counters: br_count increments on each handshake-out (valid && out_ready) of a jal, jalr or br op. mp_count increments on each handshake-out with mispredict=1. Both wrap at 2^CNT_BITS.

## Timing
- Reset: while rst is high, every register is held at 0. Outputs are therefore: valid=0, rd_v=0, out_rob_idx=0, out_pd=0, br_taken=0, mispredict=0, pc_select=0, pc_branch=0, br_count=0, mp_count=0. ready=1 when flush=0.
- Latency: an op accepted at rising edge N has valid=1 from just after edge N until it is handshaken out.
- Throughput: 1 op/cycle while out_ready=1.
- pc_select is registered-derived only. It has no combinational path from start, operands or flush.
- A redirect persists while the result is stalled (!out_ready). Fetch treats it as level-sensitive.
- Reset asserted mid-stall: state is EMPTY immediately (asynchronous), and any pending redirect is lost.
- flush and start in the same cycle: the op is dropped and ready=0 that cycle.
- flush with valid && out_ready in the same cycle: the handshake-out is still counted. The result is simultaneously discarded by the ROB.

## Test plan
- Reset, then issue beq with rs1=rs2=5, pc=0x100, b_imm=0x20, pred_taken=0 → next cycle valid=1, br_taken=1, mispredict=1, pc_select=1, pc_branch=0x120; mp_count=1 after handshake.
- Issue blt with rs1=0xFFFF_FFFF, rs2=1, pred_taken=1, pred_target=pc+b_imm → taken, mispredict=0, pc_select=0. Then bltu with the same operands → not taken.
- Issue jalr with rs1=0x1003, i_imm=4, pc=0x200, pred_target=0x1006 → rd_v=0x204, pc_branch=0x1006, mispredict=0. With pred_target=0x1004 → mispredict=1.
- Back-to-back issue of 4 jal ops with out_ready=1 → 4 consecutive valid cycles with matching out_rob_idx. Hold out_ready=0 for 3 cycles mid-stream → ready=0 and outputs stable until it returns to 1; br_count=4 at the end.
- Assert flush with start=1 and valid=1, out_ready=0 → next cycle valid=0, no counter change, the op is not captured.
- Assert rst asynchronously between edges while FULL → valid and pc_select drop to 0 before the next edge; both counters read 0.
